// File: rtl/stepper_move_sequencer_if.sv
// Move-command handshake between the host command logic and the stepper sequencer.
interface stepper_move_sequencer_if #(
    parameter int STEP_W   = 16,
    parameter int PERIOD_W = 16
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_dir;
    logic [STEP_W-1:0]   cmd_steps;
    logic [PERIOD_W-1:0] cmd_period;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        output cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        input  cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_move_sequencer.sv
// Point-to-point move sequencer: turns one accepted move command into evenly spaced
// step_en strobes for the coil driver, tracks absolute position and flags completion.
module stepper_move_sequencer #(
    parameter int STEP_W     = 16,
    parameter int PERIOD_W   = 16,
    parameter int MIN_PERIOD = 4,
    parameter int POS_W      = 32
) (
    input  logic                     system1000,
    input  logic                     system1000_rstn,
    stepper_move_sequencer_if.slave  cmd,
    input  logic                     abort,
    output logic                     step_dir,
    output logic                     step_en,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic signed [POS_W-1:0]  position
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      dir_q, dir_d;
    logic [STEP_W-1:0]         rem_q, rem_d;
    logic [PERIOD_W-1:0]       cnt_q, cnt_d;
    logic [PERIOD_W-1:0]       per_q, per_d;
    logic                      step_en_q, step_en_d;
    logic                      aborted_q, aborted_d;
    logic signed [POS_W-1:0]   pos_q, pos_d;
    logic [PERIOD_W-1:0]       per_accept;

    // Periods shorter than MIN_PERIOD are raised to it; the driver cannot step faster.
    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : p;
    endfunction

    function automatic logic signed [POS_W-1:0] pos_delta(input logic fwd);
        return fwd ? POS_W'(1) : {POS_W{1'b1}};
    endfunction

    assign per_accept = clamp_period(cmd.cmd_period);

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            rem_q     <= '0;
            cnt_q     <= '0;
            per_q     <= '0;
            step_en_q <= 1'b0;
            aborted_q <= 1'b0;
            pos_q     <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            step_en_q <= step_en_d;
            aborted_q <= aborted_d;
            pos_q     <= pos_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        step_en_d = 1'b0;
        aborted_d = aborted_q;
        pos_d     = pos_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    dir_d     = cmd.cmd_dir;
                    per_d     = per_accept;
                    cnt_d     = per_accept - PERIOD_W'(1);
                    aborted_d = 1'b0;
                    if (cmd.cmd_steps == '0) begin
                        state_d = S_DONE;
                    end else begin
                        // First strobe is issued on the accept edge itself.
                        state_d   = S_RUN;
                        step_en_d = 1'b1;
                        rem_d     = cmd.cmd_steps - STEP_W'(1);
                        pos_d     = pos_q + pos_delta(cmd.cmd_dir);
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (rem_q == '0) begin
                    // Trailing wait keeps the full period after the last strobe.
                    if (cnt_q <= PERIOD_W'(1)) state_d = S_DONE;
                    else                       cnt_d   = cnt_q - PERIOD_W'(1);
                end else if (cnt_q == '0) begin
                    step_en_d = 1'b1;
                    rem_d     = rem_q - STEP_W'(1);
                    cnt_d     = per_q - PERIOD_W'(1);
                    pos_d     = pos_q + pos_delta(dir_q);
                end else begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign aborted       = (state_q == S_DONE) && aborted_q;
    assign step_en       = step_en_q;
    assign step_dir      = dir_q;
    assign position      = pos_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Randomised bench for stepper_move_sequencer against a cycle-timeline reference model.
module tb_stepper_move_sequencer;
    localparam int STEP_W     = 16;
    localparam int PERIOD_W   = 16;
    localparam int MIN_PERIOD = 4;
    localparam int POS_W      = 32;

    logic clk = 1'b0;
    logic rstn;
    logic abort, abort8;
    logic step_dir, step_en, busy, done, aborted;
    logic [POS_W-1:0] position;
    logic step_dir8, step_en8, busy8, done8, aborted8;
    logic [7:0] position8;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mpos;

    always #5 clk = ~clk;

    stepper_move_sequencer_if #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W)) bus  ();
    stepper_move_sequencer_if #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W)) bus8 ();

    stepper_move_sequencer #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W), .MIN_PERIOD(MIN_PERIOD), .POS_W(POS_W)) dut (
        .system1000(clk), .system1000_rstn(rstn), .cmd(bus), .abort(abort),
        .step_dir(step_dir), .step_en(step_en), .busy(busy), .done(done),
        .aborted(aborted), .position(position));

    stepper_move_sequencer #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W), .MIN_PERIOD(MIN_PERIOD), .POS_W(8)) dut8 (
        .system1000(clk), .system1000_rstn(rstn), .cmd(bus8), .abort(abort8),
        .step_dir(step_dir8), .step_en(step_en8), .busy(busy8), .done(done8),
        .aborted(aborted8), .position(position8));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".ready"},   64'(bus.cmd_ready), 64'd1);
        check_eq({tag, ".busy"},    64'(busy),     64'd0);
        check_eq({tag, ".done"},    64'(done),     64'd0);
        check_eq({tag, ".aborted"}, 64'(aborted),  64'd0);
        check_eq({tag, ".step_en"}, 64'(step_en),  64'd0);
        check_eq({tag, ".dir"},     64'(step_dir), 64'd0);
        check_eq({tag, ".pos"},     64'(position), 64'd0);
    endtask

    // Called at a falling edge; leaves the bench at a falling edge.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check_reset_outputs("reset");
        mpos = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Reference: cycle c=1 is the first cycle after the accept edge. Strobes appear at
    // c = 1 + k*P for k < N; completion at c = N*P (or 1 for N = 0). An abort held
    // during RUN cycle a ends the move with done in cycle a+1; strobes after a are lost.
    task automatic run_move(input string tag, input bit dir, input int steps, input int period,
                            input int abort_at, input bit noise);
        int  p, dn, d;
        bit  ab, exp_en;
        p  = (period < MIN_PERIOD) ? MIN_PERIOD : period;
        dn = (steps == 0) ? 1 : steps * p;
        ab = (abort_at >= 1) && (abort_at < dn);
        d  = ab ? abort_at + 1 : dn;
        check_eq({tag, ".idle_ready"}, 64'(bus.cmd_ready), 64'd1);
        check_eq({tag, ".idle_busy"},  64'(busy),          64'd0);
        bus.cmd_valid  = 1'b1;
        bus.cmd_dir    = dir;
        bus.cmd_steps  = STEP_W'(steps);
        bus.cmd_period = PERIOD_W'(period);
        abort          = 1'b0;
        for (int c = 1; c <= d; c++) begin
            @(negedge clk);
            exp_en = (steps > 0) && ((c - 1) % p == 0) && ((c - 1) / p < steps) && (!ab || c <= abort_at);
            if (exp_en) mpos = dir ? mpos + 32'd1 : mpos - 32'd1;
            check_eq({tag, ".step_en"}, 64'(step_en),       64'(exp_en));
            check_eq({tag, ".pos"},     64'(position),      64'(mpos));
            check_eq({tag, ".dir"},     64'(step_dir),      64'(dir));
            check_eq({tag, ".busy"},    64'(busy),          64'd1);
            check_eq({tag, ".ready"},   64'(bus.cmd_ready), 64'd0);
            check_eq({tag, ".done"},    64'(done),          64'(c == d));
            check_eq({tag, ".aborted"}, 64'(aborted),       64'((c == d) && ab));
            abort = (c == abort_at);
            bus.cmd_valid  = noise && (c < d) && ($urandom_range(1, 0) == 1);
            bus.cmd_dir    = 1'($urandom);
            bus.cmd_steps  = STEP_W'($urandom_range(9, 0));
            bus.cmd_period = PERIOD_W'($urandom_range(9, 0));
        end
        @(negedge clk);
        abort = 1'b0;
        check_eq({tag, ".end_ready"}, 64'(bus.cmd_ready), 64'd1);
        check_eq({tag, ".end_busy"},  64'(busy),          64'd0);
        check_eq({tag, ".end_done"},  64'(done),          64'd0);
        check_eq({tag, ".end_en"},    64'(step_en),       64'd0);
        check_eq({tag, ".end_pos"},   64'(position),      64'(mpos));
        check_eq({tag, ".end_dir"},   64'(step_dir),      64'(dir));
    endtask

    // Narrow-position instance: issue a forward move and wait for its done pulse.
    task automatic move8(input string tag, input int steps, input logic [7:0] exp_pos);
        bit seen;
        seen = 1'b0;
        bus8.cmd_valid  = 1'b1;
        bus8.cmd_dir    = 1'b1;
        bus8.cmd_steps  = STEP_W'(steps);
        bus8.cmd_period = PERIOD_W'(MIN_PERIOD);
        @(negedge clk);
        bus8.cmd_valid = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            if (done8) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq({tag, ".done_seen"}, 64'(seen), 64'd1);
        check_eq({tag, ".pos"}, 64'(position8), 64'(exp_pos));
        @(negedge clk);
    endtask

    initial begin
        int dir_r, steps_r, per_r, ab_r, done_cnt;
        rstn = 1'b1;
        abort = 1'b0;
        abort8 = 1'b0;
        bus.cmd_valid = 1'b0;  bus.cmd_dir = 1'b0;  bus.cmd_steps = '0;  bus.cmd_period = '0;
        bus8.cmd_valid = 1'b0; bus8.cmd_dir = 1'b0; bus8.cmd_steps = '0; bus8.cmd_period = '0;
        mpos = '0;
        @(negedge clk);
        do_reset();

        run_move("fwd3_p5", 1'b1, 3, 5, 0, 1'b0);
        check_eq("fwd3_p5.final", 64'(position), 64'd3);
        do_reset();
        run_move("rev2_clamp", 1'b0, 2, 1, 0, 1'b0);
        check_eq("rev2_clamp.final", 64'(position), 64'hFFFF_FFFE);
        run_move("zero_steps", 1'b1, 0, 7, 0, 1'b1);
        run_move("zero_abort", 1'b0, 0, 3, 1, 1'b0);
        do_reset();
        run_move("abort_3rd", 1'b1, 10, 4, 8, 1'b1);
        check_eq("abort_3rd.final", 64'(position), 64'd2);
        run_move("abort_done", 1'b0, 2, 4, 8, 1'b0);
        run_move("abort_first", 1'b1, 3, 6, 1, 1'b1);

        for (int k = 0; k < 40; k++) begin
            dir_r   = $urandom_range(1, 0);
            steps_r = $urandom_range(6, 0);
            per_r   = $urandom_range(9, 0);
            ab_r    = ($urandom_range(2, 0) == 0) ? $urandom_range(30, 1) : 0;
            run_move("rand", 1'(dir_r), steps_r, per_r, ab_r, 1'b1);
        end

        move8("wrap8_fill", 127, 8'h7F);
        move8("wrap8_step", 1, 8'h80);

        // Reset while a strobe is on the wire: everything drops at once, no done follows.
        bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b1; bus.cmd_steps = 16'd5; bus.cmd_period = 16'd4;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check_eq("midrst.pre_en", 64'(step_en), 64'd1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check_eq("midrst.pos8", 64'(position8), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || step_en || busy) done_cnt++;
        end
        check_eq("midrst.quiet", 64'(done_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
